// File: rtl/gpio_irq_aggregator.sv
// APB3 interrupt aggregator for the GPIO block: per-source edge/level capture, enable masking,
// registered IRQ/IRQ_ID and a claim register. Optional input synchroniser: GPIO_IRQ_SYNC_EN.
module gpio_irq_aggregator #(
    parameter int NUM_IRQ = 21,
    parameter int ID_W    = 5
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_IRQ-1:0]  INT_IN,
    input  logic [7:0]          PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                IRQ,
    output logic [ID_W-1:0]     IRQ_ID
);

    localparam logic [5:0]         W_PENDING = 6'd0;
    localparam logic [5:0]         W_ENABLE  = 6'd1;
    localparam logic [5:0]         W_MODE    = 6'd2;
    localparam logic [5:0]         W_CLEAR   = 6'd3;
    localparam logic [5:0]         W_CLAIM   = 6'd4;
    localparam logic [NUM_IRQ-1:0] ZERO_N    = {NUM_IRQ{1'b0}};
    localparam logic [NUM_IRQ-1:0] ONE_N     = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    ZERO_ID   = {ID_W{1'b0}};
    localparam logic [ID_W-1:0]    ONE_ID    = {{(ID_W-1){1'b0}}, 1'b1};

    // Lowest set index plus one; zero when no bit is set.
    function automatic logic [ID_W-1:0] prio_id(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] id;
        id = ZERO_ID;
        for (int i = NUM_IRQ - 32'sd1; i >= 32'sd0; i--) begin
            id = v[i] ? (ID_W'(i) + ONE_ID) : id;
        end
        return id;
    endfunction

    // One-hot of the lowest set bit (two's-complement isolate).
    function automatic logic [NUM_IRQ-1:0] lowest_bit(input logic [NUM_IRQ-1:0] v);
        return v & (~v + ONE_N);
    endfunction

    logic [NUM_IRQ-1:0] pending_r, enable_r, mode_r, int_q_r;
    logic [NUM_IRQ-1:0] src_s, set_s, active_s, clear_s, claim_clr_s;
    logic [NUM_IRQ-1:0] pending_nxt_s, enable_nxt_s, mode_nxt_s, wdata_s;
    logic [ID_W-1:0]    claim_id_s;
    logic [5:0]         word_s;
    logic               access_s, addr_err_s, wr_s, rd_s;
    logic [31:0]        rdata_s;
    logic               irq_r;
    logic [ID_W-1:0]    irq_id_r;
    logic               unused_s;

`ifdef GPIO_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_r, sync2_r;

    // Two-flop synchroniser for sources from an unrelated clock domain.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_r <= ZERO_N;
            sync2_r <= ZERO_N;
        end else begin
            sync1_r <= INT_IN;
            sync2_r <= sync1_r;
        end
    end

    assign src_s = sync2_r;
`else
    assign src_s = INT_IN;
`endif

    assign word_s   = PADDR[7:2];
    assign wdata_s  = PWDATA[NUM_IRQ-1:0];
    assign unused_s = ^{PADDR[1:0], PWDATA[31:NUM_IRQ]};
    assign access_s = PSEL & PENABLE;

    // Address/direction legality for the current access.
    always_comb begin
        addr_err_s = 1'b0;
        case (word_s)
            W_PENDING: addr_err_s = PWRITE;
            W_ENABLE:  addr_err_s = 1'b0;
            W_MODE:    addr_err_s = 1'b0;
            W_CLEAR:   addr_err_s = ~PWRITE;
            W_CLAIM:   addr_err_s = PWRITE;
            default:   addr_err_s = 1'b1;
        endcase
    end

    assign wr_s = access_s & PWRITE & ~addr_err_s;
    assign rd_s = access_s & ~PWRITE & ~addr_err_s;

    assign active_s   = pending_r & enable_r;
    assign claim_id_s = prio_id(active_s);
    assign set_s      = (mode_r & src_s & ~int_q_r) | (~mode_r & src_s);

    // Clear sources: W1C write and the claim side effect; errored accesses never reach here.
    always_comb begin
        clear_s     = ZERO_N;
        claim_clr_s = ZERO_N;
        if (wr_s && (word_s == W_CLEAR)) begin
            clear_s = wdata_s;
        end else begin
            clear_s = ZERO_N;
        end
        if (rd_s && (word_s == W_CLAIM)) begin
            claim_clr_s = lowest_bit(active_s);
        end else begin
            claim_clr_s = ZERO_N;
        end
    end

    // Set has priority over clear, so a source still asserting re-pends on the claim edge.
    assign pending_nxt_s = (pending_r & ~(clear_s | claim_clr_s)) | set_s;

    // Next values of the RW configuration registers.
    always_comb begin
        enable_nxt_s = enable_r;
        mode_nxt_s   = mode_r;
        if (wr_s && (word_s == W_ENABLE)) begin
            enable_nxt_s = wdata_s;
        end else begin
            enable_nxt_s = enable_r;
        end
        if (wr_s && (word_s == W_MODE)) begin
            mode_nxt_s = wdata_s;
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Interrupt state and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pending_r <= ZERO_N;
            enable_r  <= ZERO_N;
            mode_r    <= ZERO_N;
            int_q_r   <= ZERO_N;
            irq_r     <= 1'b0;
            irq_id_r  <= ZERO_ID;
        end else begin
            pending_r <= pending_nxt_s;
            enable_r  <= enable_nxt_s;
            mode_r    <= mode_nxt_s;
            int_q_r   <= src_s;
            irq_r     <= |active_s;
            irq_id_r  <= claim_id_s;
        end
    end

    // Read mux; forced to zero while reset is asserted so a dropped access returns nothing.
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s && !PRESET) begin
            case (word_s)
                W_PENDING: rdata_s = {{(32-NUM_IRQ){1'b0}}, pending_r};
                W_ENABLE:  rdata_s = {{(32-NUM_IRQ){1'b0}}, enable_r};
                W_MODE:    rdata_s = {{(32-NUM_IRQ){1'b0}}, mode_r};
                W_CLAIM:   rdata_s = {{(32-ID_W){1'b0}}, claim_id_s};
                default:   rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign PRDATA  = rdata_s;
    assign PSLVERR = access_s & addr_err_s & ~PRESET;
    assign PREADY  = 1'b1;
    assign IRQ     = irq_r;
    assign IRQ_ID  = irq_id_r;

endmodule

// File: tb/tb_gpio_irq_aggregator.sv
// Self-checking bench for gpio_irq_aggregator: directed scenarios plus randomized traffic
// compared against a bit-level behavioural model.
module tb_gpio_irq_aggregator;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [20:0] INT_IN;
    logic [7:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, IRQ;
    logic [4:0]  IRQ_ID;

    int passed = 0;
    int total  = 0;

    gpio_irq_aggregator #(.NUM_IRQ(21), .ID_W(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .INT_IN(INT_IN), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
    );

    always #5 PCLK = ~PCLK;

    // Reference model state
    logic [20:0] m_pending, m_enable, m_mode, m_prev;
    logic        m_irq;
    logic [4:0]  m_irq_id;

    function automatic int lowest(input logic [20:0] v);
        int r = -1;
        for (int i = 20; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic m_err(input logic [7:0] a, input logic w);
        logic [7:0] b = {a[7:2], 2'b00};
        return (b > 8'h10) || (w && (b == 8'h00 || b == 8'h10)) || (!w && b == 8'h0C);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [7:0] b = {a[7:2], 2'b00};
        if (m_err(a, 1'b0)) return 32'd0;
        if (b == 8'h00) return {11'd0, m_pending};
        if (b == 8'h04) return {11'd0, m_enable};
        if (b == 8'h08) return {11'd0, m_mode};
        if (b == 8'h10) return 32'(lowest(m_pending & m_enable) + 1);
        return 32'd0;
    endfunction

    function automatic logic [20:0] next_pending();
        logic [20:0] p = m_pending;
        logic [7:0]  b = {PADDR[7:2], 2'b00};
        int lo;
        if (PSEL && PENABLE && !m_err(PADDR, PWRITE)) begin
            if (PWRITE && b == 8'h0C) p = p & ~PWDATA[20:0];
            if (!PWRITE && b == 8'h10) begin
                lo = lowest(m_pending & m_enable);
                if (lo >= 0) p[lo] = 1'b0;
            end
        end
        for (int i = 0; i < 21; i++)
            if (m_mode[i] ? (INT_IN[i] && !m_prev[i]) : INT_IN[i]) p[i] = 1'b1;
        return p;
    endfunction

    function automatic logic [20:0] next_cfg(input logic [7:0] off, input logic [20:0] cur);
        if (PSEL && PENABLE && PWRITE && !m_err(PADDR, 1'b1) && {PADDR[7:2], 2'b00} == off)
            return PWDATA[20:0];
        return cur;
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_pending <= 21'd0; m_enable <= 21'd0; m_mode <= 21'd0; m_prev <= 21'd0;
            m_irq <= 1'b0; m_irq_id <= 5'd0;
        end else begin
            m_pending <= next_pending();
            m_enable  <= next_cfg(8'h04, m_enable);
            m_mode    <= next_cfg(8'h08, m_mode);
            m_prev    <= INT_IN;
            m_irq     <= |(m_pending & m_enable);
            m_irq_id  <= 5'(lowest(m_pending & m_enable) + 1);
        end
    end

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er,
                            output logic [31:0] erd, output logic eer);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; #3;
        rd = PRDATA; er = PSLVERR; erd = m_read(a); eer = m_err(a, w);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, output logic er);
        logic [31:0] rd, erd; logic eer;
        apb_xfer(1'b1, a, d, rd, er, erd, eer);
    endtask

    task automatic rdr(input logic [7:0] a, output logic [31:0] rd, output logic er);
        logic [31:0] erd; logic eer;
        apb_xfer(1'b0, a, 32'd0, rd, er, erd, eer);
    endtask

    task automatic test_reset();
        logic er;
        INT_IN = 21'h1;
        wr(8'h04, 32'h1, er);
        tick(); tick();
        total++; if (IRQ !== 1'b1) $display("FAIL pre_reset_irq got %0h exp 1", IRQ); else passed++;
        PSEL = 1'b1; PADDR = 8'h04; PWRITE = 1'b0; tick();
        PENABLE = 1'b1; #2;
        total++; if (PRDATA !== 32'h1) $display("FAIL pre_reset_rdata got %h exp 1", PRDATA); else passed++;
        PRESET = 1'b1; #1;
        total++; if (IRQ !== 1'b0) $display("FAIL reset_irq got %0h exp 0", IRQ); else passed++;
        total++; if (IRQ_ID !== 5'd0) $display("FAIL reset_irq_id got %0d exp 0", IRQ_ID); else passed++;
        total++; if (PRDATA !== 32'd0) $display("FAIL reset_prdata got %h exp 0", PRDATA); else passed++;
        total++; if (PSLVERR !== 1'b0) $display("FAIL reset_pslverr got %0h exp 0", PSLVERR); else passed++;
        total++; if (PREADY !== 1'b1) $display("FAIL reset_pready got %0h exp 1", PREADY); else passed++;
        PSEL = 1'b0; PENABLE = 1'b0; INT_IN = 21'd0;
        @(posedge PCLK); #3; PRESET = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] d;
            rdr(8'(k * 4), d, er);
            total++; if (d !== 32'd0) $display("FAIL reset_read_%0d got %h exp 0", k * 4, d); else passed++;
        end
    endtask

    task automatic test_edge();
        logic er; logic [31:0] d;
        wr(8'h08, 32'h10, er);
        wr(8'h04, 32'h10, er);
        INT_IN = 21'h10; tick(); INT_IN = 21'd0; #3;
        total++; if (IRQ !== 1'b0) $display("FAIL edge_irq_early got %0h exp 0", IRQ); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h10) $display("FAIL edge_pending got %h exp 10", d); else passed++;
        total++; if (IRQ !== 1'b1 || IRQ_ID !== 5'd5)
            $display("FAIL edge_irq got %0h/%0d exp 1/5", IRQ, IRQ_ID); else passed++;
        rdr(8'h10, d, er);
        total++; if (d !== 32'd5) $display("FAIL edge_claim got %0d exp 5", d); else passed++;
        tick();
        total++; if (IRQ !== 1'b0) $display("FAIL edge_irq_after_claim got %0h exp 0", IRQ); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h0) $display("FAIL edge_pending_cleared got %h exp 0", d); else passed++;
    endtask

    task automatic test_priority_level();
        logic er; logic [31:0] d;
        wr(8'h08, 32'h0, er);
        wr(8'h04, 32'h1FFFFF, er);
        INT_IN = 21'h80002; tick(); tick();
        total++; if (IRQ_ID !== 5'd2) $display("FAIL prio_irq_id got %0d exp 2", IRQ_ID); else passed++;
        rdr(8'h10, d, er);
        total++; if (d !== 32'd2) $display("FAIL prio_claim got %0d exp 2", d); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h80002) $display("FAIL level_repend got %h exp 80002", d); else passed++;
        INT_IN = 21'd0;
        wr(8'h0C, 32'h2, er);
        rdr(8'h10, d, er);
        total++; if (d !== 32'd20) $display("FAIL prio_claim2 got %0d exp 20", d); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h0) $display("FAIL prio_pending_empty got %h exp 0", d); else passed++;
    endtask

    task automatic test_masking();
        logic er; logic [31:0] d;
        wr(8'h04, 32'h0, er);
        wr(8'h08, 32'h400, er);
        INT_IN = 21'h400; tick(); INT_IN = 21'd0;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h400) $display("FAIL mask_pending got %h exp 400", d); else passed++;
        total++; if (IRQ !== 1'b0) $display("FAIL mask_irq got %0h exp 0", IRQ); else passed++;
        rdr(8'h10, d, er);
        total++; if (d !== 32'd0) $display("FAIL mask_claim got %0d exp 0", d); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h400) $display("FAIL mask_pending_kept got %h exp 400", d); else passed++;
        wr(8'h04, 32'h400, er);
        total++; if (IRQ !== 1'b0) $display("FAIL unmask_irq_early got %0h exp 0", IRQ); else passed++;
        tick();
        total++; if (IRQ !== 1'b1 || IRQ_ID !== 5'd11)
            $display("FAIL unmask_irq got %0h/%0d exp 1/11", IRQ, IRQ_ID); else passed++;
        rdr(8'h10, d, er);
        total++; if (d !== 32'd11) $display("FAIL unmask_claim got %0d exp 11", d); else passed++;
    endtask

    task automatic test_collision();
        logic er; logic [31:0] d;
        wr(8'h08, 32'h1000, er);
        wr(8'h04, 32'h1000, er);
        INT_IN = 21'h1000; tick(); INT_IN = 21'd0; tick();
        PSEL = 1'b1; PADDR = 8'h0C; PWRITE = 1'b1; PWDATA = 32'h1000; tick();
        PENABLE = 1'b1; INT_IN = 21'h1000; tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; INT_IN = 21'd0;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h1000) $display("FAIL collision_set_wins got %h exp 1000", d); else passed++;
        wr(8'h0C, 32'h1000, er);
        rdr(8'h00, d, er);
        total++; if (d !== 32'h0) $display("FAIL collision_cleared got %h exp 0", d); else passed++;
    endtask

    task automatic test_errors();
        logic er; logic [31:0] d;
        INT_IN = 21'h1000; tick(); INT_IN = 21'd0;
        wr(8'h10, 32'hFFFFFFFF, er);
        total++; if (er !== 1'b1) $display("FAIL err_write_claim got %0h exp 1", er); else passed++;
        wr(8'h00, 32'h0, er);
        total++; if (er !== 1'b1) $display("FAIL err_write_pending got %0h exp 1", er); else passed++;
        rdr(8'h14, d, er);
        total++; if (er !== 1'b1) $display("FAIL err_read_14 got %0h exp 1", er); else passed++;
        rdr(8'h0C, d, er);
        total++; if (er !== 1'b1) $display("FAIL err_read_clear got %0h exp 1", er); else passed++;
        wr(8'h14, 32'h0, er);
        total++; if (er !== 1'b1) $display("FAIL err_write_14 got %0h exp 1", er); else passed++;
        rdr(8'h04, d, er);
        total++; if (d !== 32'h1000 || er !== 1'b0)
            $display("FAIL err_enable_kept got %h/%0h exp 1000/0", d, er); else passed++;
        rdr(8'h00, d, er);
        total++; if (d !== 32'h1000) $display("FAIL err_pending_kept got %h exp 1000", d); else passed++;
        total++; if (IRQ !== 1'b1 || IRQ_ID !== 5'd13)
            $display("FAIL err_irq_kept got %0h/%0d exp 1/13", IRQ, IRQ_ID); else passed++;
    endtask

    task automatic test_random();
        logic [7:0]  addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h10, 8'h14, 8'h20};
        logic [31:0] rd, erd; logic er, eer;
        int op;
        for (int it = 0; it < 200; it++) begin
            INT_IN = 21'($urandom) & 21'($urandom) & 21'($urandom);
            op = $urandom_range(0, 5);
            case (op)
                0: tick();
                1: apb_xfer(1'b1, 8'h04, $urandom, rd, er, erd, eer);
                2: apb_xfer(1'b1, 8'h08, $urandom, rd, er, erd, eer);
                3: apb_xfer(1'b1, 8'h0C, $urandom, rd, er, erd, eer);
                4: apb_xfer(1'b0, addrs[$urandom_range(0, 7)], 32'd0, rd, er, erd, eer);
                default: apb_xfer(1'b1, addrs[$urandom_range(0, 7)], $urandom, rd, er, erd, eer);
            endcase
            if (op != 0) begin
                total++; if (er !== eer) $display("FAIL rand_pslverr it=%0d got %0h exp %0h", it, er, eer); else passed++;
            end
            if (op == 4) begin
                total++; if (rd !== erd) $display("FAIL rand_prdata it=%0d got %h exp %h", it, rd, erd); else passed++;
            end
            total++; if (IRQ !== m_irq || IRQ_ID !== m_irq_id)
                $display("FAIL rand_irq it=%0d got %0h/%0d exp %0h/%0d", it, IRQ, IRQ_ID, m_irq, m_irq_id);
            else passed++;
        end
    endtask

    initial begin
        PRESET = 1'b1; INT_IN = 21'd0; PADDR = 8'd0; PSEL = 1'b0; PENABLE = 1'b0;
        PWRITE = 1'b0; PWDATA = 32'd0;
        #12 PRESET = 1'b0;
        tick();
        test_reset();
        test_edge();
        test_priority_level();
        test_masking();
        test_collision();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
